// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multi-cycle core (IDLE/FETCH/EXEC/WAIT_DIN/NEXT/HALT) with loadable program memory.
// Optional feature macro PROC_MUL_EN: builds the DATA_W x DATA_W multiplier for opcode 4 (NOP when undefined).
module proc_core_param #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned GPR_N      = 32,
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);
  localparam int unsigned PC_W   = $clog2(PROG_DEPTH);
  localparam int unsigned DA_W   = $clog2(DMEM_DEPTH);
  localparam int unsigned RI_W   = $clog2(GPR_N);
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [4:0] OP_MOVSGPR = 5'd0,  OP_MOV      = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4,  OP_OR       = 5'd5,  OP_AND  = 5'd6,  OP_XOR  = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8,  OP_NAND     = 5'd9,  OP_NOR  = 5'd10, OP_NOT  = 5'd11;
  localparam logic [4:0] OP_STOREREG = 5'd13, OP_STOREDIN = 5'd14, OP_SENDDOUT = 5'd15, OP_SENDREG = 5'd17;
  localparam logic [4:0] OP_JMP = 5'd18, OP_JC = 5'd19, OP_JNC = 5'd20, OP_JS = 5'd21, OP_JNS = 5'd22;
  localparam logic [4:0] OP_JZ  = 5'd23, OP_JNZ = 5'd24, OP_JO = 5'd25, OP_JNO = 5'd26, OP_HALT = 5'd27;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT_DIN, S_NEXT, S_HALT} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_gpr [GPR_N];
  logic [DATA_W-1:0] r_sgpr;
  logic              r_sign, r_zero, r_carry, r_ovf;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid, r_busy, r_halted;
  logic [31:0]       r_imem [PROG_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  logic [4:0]        w_op;
  logic [RI_W-1:0]   w_rdst, w_rs1, w_rs2;
  logic              w_imm_mode;
  logic [DATA_W-1:0] w_imm, w_a, w_b, w_dmem_rd, w_dmem_wdata;
  logic [DA_W-1:0]   w_daddr;
  logic [PC_W-1:0]   w_target;
  logic              w_dmem_we, w_jump;

  assign w_op       = r_ir[31:27];
  assign w_rdst     = r_ir[22 +: RI_W];
  assign w_rs1      = r_ir[17 +: RI_W];
  assign w_imm_mode = r_ir[16];
  assign w_rs2      = r_ir[11 +: RI_W];
  assign w_imm      = DATA_W'(r_ir[15:0]);
  assign w_daddr    = DA_W'(r_ir[15:0]);
  assign w_target   = PC_W'(r_ir[15:0]);
  assign w_a        = r_gpr[w_rs1];
  assign w_b        = w_imm_mode ? w_imm : r_gpr[w_rs2];
  assign w_dmem_rd  = r_dmem[w_daddr];

  // ALU: result, write enables and flag values for the instruction held in IR
  logic [DATA_W-1:0] w_res, w_sgpr_nxt;
  logic [DATA_W:0]   w_sum, w_diff;
  logic              w_gpr_we, w_sgpr_we, w_flag_we, w_zero, w_carry, w_ovf;
`ifdef PROC_MUL_EN
  logic [PROD_W-1:0] w_prod;
  assign w_prod = PROD_W'(w_a) * PROD_W'(w_b);
`endif

  always_comb begin
    w_res      = '0;
    w_sgpr_nxt = r_sgpr;
    w_gpr_we   = 1'b0;
    w_sgpr_we  = 1'b0;
    w_flag_we  = 1'b0;
    w_carry    = 1'b0;
    w_ovf      = 1'b0;
    w_sum      = {1'b0, w_a} + {1'b0, w_b};
    w_diff     = {1'b0, w_a} - {1'b0, w_b};
    case (w_op)
      OP_MOVSGPR: begin w_res = r_sgpr; w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_MOV:     begin w_res = w_imm_mode ? w_imm : w_a; w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_ADD: begin
        w_res     = w_sum[DATA_W-1:0];
        w_carry   = w_sum[DATA_W];
        w_ovf     = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
        w_gpr_we  = 1'b1;
        w_flag_we = 1'b1;
      end
      OP_SUB: begin
        w_res     = w_diff[DATA_W-1:0];
        w_carry   = w_diff[DATA_W];
        w_ovf     = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
        w_gpr_we  = 1'b1;
        w_flag_we = 1'b1;
      end
      OP_MUL: begin
`ifdef PROC_MUL_EN
        w_res      = w_prod[DATA_W-1:0];
        w_sgpr_nxt = w_prod[PROD_W-1:DATA_W];
        w_gpr_we   = 1'b1;
        w_sgpr_we  = 1'b1;
        w_flag_we  = 1'b1;
`endif
      end
      OP_OR:      begin w_res = w_a | w_b;    w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_AND:     begin w_res = w_a & w_b;    w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_XOR:     begin w_res = w_a ^ w_b;    w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_XNOR:    begin w_res = ~(w_a ^ w_b); w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_NAND:    begin w_res = ~(w_a & w_b); w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_NOR:     begin w_res = ~(w_a | w_b); w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_NOT:     begin w_res = ~w_a;         w_gpr_we = 1'b1; w_flag_we = 1'b1; end
      OP_SENDREG: begin w_res = w_dmem_rd;    w_gpr_we = 1'b1; end
      default: ;
    endcase
    w_zero = (w_res == '0);
`ifdef PROC_MUL_EN
    if (w_op == OP_MUL) w_zero = (w_prod == '0);
`endif
  end

  // Branch decision uses the flags left by the previous EXEC
  always_comb begin
    case (w_op)
      OP_JMP:  w_jump = 1'b1;
      OP_JC:   w_jump = r_carry;
      OP_JNC:  w_jump = !r_carry;
      OP_JS:   w_jump = r_sign;
      OP_JNS:  w_jump = !r_sign;
      OP_JZ:   w_jump = r_zero;
      OP_JNZ:  w_jump = !r_zero;
      OP_JO:   w_jump = r_ovf;
      OP_JNO:  w_jump = !r_ovf;
      default: w_jump = 1'b0;
    endcase
  end

  assign w_dmem_we    = ((r_state == S_EXEC) && (w_op == OP_STOREREG)) ||
                        (din_valid && (((r_state == S_EXEC) && (w_op == OP_STOREDIN)) || (r_state == S_WAIT_DIN)));
  assign w_dmem_wdata = (w_op == OP_STOREREG) ? w_a : din;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_sgpr       <= '0;
      r_sign       <= 1'b0;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_ovf        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      for (int unsigned i = 0; i < GPR_N; i++) r_gpr[i] <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_gpr_we)  r_gpr[w_rdst] <= w_res;
          if (w_sgpr_we) r_sgpr <= w_sgpr_nxt;
          if (w_flag_we) begin
            r_sign  <= w_res[DATA_W-1];
            r_zero  <= w_zero;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
          end
          if (w_op == OP_SENDDOUT) begin
            r_dout       <= w_dmem_rd;
            r_dout_valid <= 1'b1;
          end
          r_state <= ((w_op == OP_STOREDIN) && !din_valid) ? S_WAIT_DIN : S_NEXT;
        end
        S_WAIT_DIN: if (din_valid) r_state <= S_NEXT;
        S_NEXT: begin
          if (w_op == OP_HALT) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_jump ? w_target : r_pc + PC_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memories hold their contents across reset
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && imem_we) r_imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_dmem_we) r_dmem[w_daddr] <= w_dmem_wdata;
  end

  assign din_ready  = (r_state == S_WAIT_DIN) ||
                      ((r_state == S_EXEC) && (w_op == OP_STOREDIN) && din_valid);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign halted     = r_halted;
  assign pc         = r_pc;
endmodule

// File: tb/tb_proc_core_param.sv
// Directed bench for proc_core_param (default parameters); expectations follow PROC_MUL_EN.
module tb_proc_core_param;
  logic        clk = 1'b0;
  logic        sys_rst_n, start, imem_we, din_valid, din_ready, dout_valid, busy, halted;
  logic [4:0]  imem_addr, pc;
  logic [31:0] imem_wdata;
  logic [15:0] din, dout;

  proc_core_param dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

`ifdef PROC_MUL_EN
  localparam logic [15:0] EXP_R2 = 16'h3400, EXP_R3 = 16'h0012;
`else
  localparam logic [15:0] EXP_R2 = 16'h5555, EXP_R3 = 16'h0000;
`endif
  localparam logic [31:0] NOP_W  = {5'd12, 27'd0};
  localparam logic [31:0] HALT_W = {5'd27, 27'd0};

  int          n_total = 0, n_bad = 0;
  int          n_rdy, n_dv, cyc;
  logic [15:0] last_dout;
  logic [31:0] prog [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] ins_r(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = NOP_W;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = 5'(i);
      imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts the core and counts cycles until halted; din_valid rises at cycle din_cyc (<0: never)
  task automatic run(input int budget, input int din_cyc, input bit we_hit, output int n);
    n_rdy = 0;
    n_dv  = 0;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_halted", 32'(halted), 32'd0);
    n = 0;
    while (!halted && n < budget) begin
      din_valid  = (din_cyc >= 0) && (n >= din_cyc);
      imem_we    = we_hit && (n >= 1) && (n <= 6);
      imem_addr  = 5'(n % 4);
      imem_wdata = HALT_W;
      #1;
      if (din_ready) n_rdy++;
      if (dout_valid) begin
        n_dv++;
        last_dout = dout;
      end
      @(negedge clk);
      n++;
    end
    din_valid = 1'b0;
    imem_we   = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; imem_addr = '0;
    imem_wdata = '0; din = '0; din_valid = 1'b0; last_dout = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    do_reset();

    // mov/add/halt latency and flags
    clear_prog();
    prog[0] = ins_i(5'd1, 5'd2, 5'd0, 16'd2);
    prog[1] = ins_i(5'd2, 5'd0, 5'd2, 16'd4);
    prog[2] = HALT_W;
    load_prog();
    run(60, -1, 1'b0, cyc);
    chk("t1_cycles", 32'(cyc), 32'd9);
    chk("t1_r0", 32'(dut.r_gpr[0]), 32'd6);
    chk("t1_r2", 32'(dut.r_gpr[2]), 32'd2);
    chk("t1_sign", 32'(dut.r_sign), 32'd0);
    chk("t1_zero", 32'(dut.r_zero), 32'd0);
    chk("t1_carry", 32'(dut.r_carry), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_pc", 32'(pc), 32'd2);

    // signed overflow with carry, conditional jumps
    do_reset();
    clear_prog();
    prog[0]  = ins_i(5'd1, 5'd0, 5'd0, 16'h8000);
    prog[1]  = ins_i(5'd1, 5'd1, 5'd0, 16'h8002);
    prog[2]  = ins_r(5'd2, 5'd2, 5'd0, 5'd1);
    prog[3]  = ins_i(5'd20, 5'd0, 5'd0, 16'd20);
    prog[4]  = ins_i(5'd19, 5'd0, 5'd0, 16'd10);
    prog[5]  = HALT_W;
    prog[10] = ins_i(5'd13, 5'd0, 5'd2, 16'd5);
    prog[11] = ins_i(5'd15, 5'd0, 5'd0, 16'd5);
    prog[12] = HALT_W;
    prog[20] = HALT_W;
    load_prog();
    run(100, -1, 1'b0, cyc);
    chk("t2_cycles", 32'(cyc), 32'd24);
    chk("t2_pc", 32'(pc), 32'd12);
    chk("t2_dout", 32'(last_dout), 32'h0002);
    chk("t2_carry", 32'(dut.r_carry), 32'd1);
    chk("t2_ovf", 32'(dut.r_ovf), 32'd1);
    chk("t2_sign", 32'(dut.r_sign), 32'd0);

    // multiply and SGPR transfer
    do_reset();
    clear_prog();
    prog[0] = ins_i(5'd1, 5'd0, 5'd0, 16'h1234);
    prog[1] = ins_i(5'd1, 5'd2, 5'd0, 16'h5555);
    prog[2] = ins_i(5'd4, 5'd2, 5'd0, 16'h0100);
    prog[3] = ins_i(5'd0, 5'd3, 5'd0, 16'd0);
    prog[4] = HALT_W;
    load_prog();
    run(60, -1, 1'b0, cyc);
    chk("t4_cycles", 32'(cyc), 32'd15);
    chk("t4_r0", 32'(dut.r_gpr[0]), 32'h1234);
    chk("t4_r2", 32'(dut.r_gpr[2]), 32'(EXP_R2));
    chk("t4_r3", 32'(dut.r_gpr[3]), 32'(EXP_R3));

    // storedin with a 6-cycle din stall, then senddout
    do_reset();
    clear_prog();
    prog[0] = ins_i(5'd14, 5'd0, 5'd0, 16'd3);
    prog[1] = ins_i(5'd15, 5'd0, 5'd0, 16'd3);
    prog[2] = HALT_W;
    load_prog();
    din = 16'hBEEF;
    run(60, 7, 1'b0, cyc);
    chk("t3_cycles", 32'(cyc), 32'd15);
    chk("t3_din_ready_cycles", 32'(n_rdy), 32'd6);
    chk("t3_dout_valid_cycles", 32'(n_dv), 32'd1);
    chk("t3_dout", 32'(last_dout), 32'hBEEF);

    // storedin with din already valid: no stall
    clear_prog();
    prog[0] = ins_i(5'd14, 5'd0, 5'd0, 16'd4);
    prog[1] = ins_i(5'd15, 5'd0, 5'd0, 16'd4);
    prog[2] = HALT_W;
    do_reset();
    load_prog();
    din = 16'h1234;
    run(60, 0, 1'b0, cyc);
    chk("t3b_cycles", 32'(cyc), 32'd9);
    chk("t3b_din_ready_cycles", 32'(n_rdy), 32'd1);
    chk("t3b_dout", 32'(last_dout), 32'h1234);

    // program writes ignored while busy or halted; restart reruns the program
    do_reset();
    clear_prog();
    prog[0] = ins_i(5'd1, 5'd1, 5'd0, 16'd7);
    prog[1] = ins_i(5'd2, 5'd1, 5'd1, 16'd1);
    prog[2] = ins_i(5'd13, 5'd0, 5'd1, 16'd2);
    prog[3] = ins_i(5'd15, 5'd0, 5'd0, 16'd2);
    prog[4] = HALT_W;
    load_prog();
    run(60, -1, 1'b1, cyc);
    chk("t6_cycles", 32'(cyc), 32'd15);
    chk("t6_dout", 32'(last_dout), 32'd8);
    @(negedge clk);
    imem_we = 1'b1; imem_addr = 5'd0; imem_wdata = HALT_W;
    @(negedge clk);
    imem_we = 1'b0;
    last_dout = '0;
    run(60, -1, 1'b0, cyc);
    chk("t6_rerun_cycles", 32'(cyc), 32'd15);
    chk("t6_rerun_dout", 32'(last_dout), 32'd8);
    chk("t6_rerun_halted", 32'(halted), 32'd1);

    // PC wrap 31->0 and asynchronous reset during EXEC
    do_reset();
    clear_prog();
    prog[0] = ins_i(5'd18, 5'd0, 5'd0, 16'd31);
    load_prog();
    pulse_start();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 3) chk("t5_pc_31", 32'(pc), 32'd31);
      if (n == 6) chk("t5_pc_wrap", 32'(pc), 32'd0);
      if (n == 9) chk("t5_pc_31_again", 32'(pc), 32'd31);
    end
    chk("t5_busy_before", 32'(busy), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_pc", 32'(pc), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("t5_rst_din_ready", 32'(din_ready), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_pc", 32'(pc), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
